// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the sync generator and the
// downstream pattern stage (which uses the same active-area limits).
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Map a logical "sync asserted" onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic asserted, input bit active_low);
    return active_low ? ~asserted : asserted;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle driven by vga_sync_gen and consumed by the pattern stage
// and the VGA connector.
interface vga_sync_gen_if;
  import vga_pkg::*;

  logic               pix_tick;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               video_on;
  logic               hsync;
  logic               vsync;
  logic               line_start;
  logic               frame_start;

  modport master (
    output pix_tick, x, y, video_on, hsync, vsync, line_start, frame_start
  );

  modport slave (
    input pix_tick, x, y, video_on, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// System-clock divider: emits a registered one-clk pix_tick every CLK_DIV clks.
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // With CLK_DIV=1 div_cnt sits at 0 and the tick stays high after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      pix_tick <= 1'b0;
    end else begin
      if (div_cnt == CNT_LAST) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;
      pix_tick <= (div_cnt == CNT_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster generator: pixel coordinates, sync pulses, blanking
// qualifier and line/frame strobes, all registered and mutually cycle-aligned.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
  parameter int CLK_DIV         = DEF_CLK_DIV
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV=%0d outside 1..16", CLK_DIV);
  end

  function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

  logic               vld_p0;
  logic               x_wrap_p0;
  logic               y_wrap_p0;
  logic [COORD_W-1:0] x_p0;
  logic [COORD_W-1:0] y_p0;

  logic [COORD_W-1:0] x_p1;
  logic [COORD_W-1:0] y_p1;
  logic               video_on_p1;
  logic               hsync_p1;
  logic               vsync_p1;
  logic               line_start_p1;
  logic               frame_start_p1;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (vld_p0)
  );

  // Stage p0: next raster position, applied only when vld_p0 is high
  always_comb begin
    x_wrap_p0 = (x_p1 == X_LAST);
    y_wrap_p0 = (y_p1 == Y_LAST);
    x_p0      = x_wrap_p0 ? '0 : x_p1 + 1'b1;
    y_p0      = y_p1;
    if (x_wrap_p0) y_p0 = y_wrap_p0 ? '0 : y_p1 + 1'b1;
  end

  // Stage p1: counters plus decodes of the same next position, so they align
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p1           <= X_LAST;
      y_p1           <= Y_LAST;
      video_on_p1    <= 1'b0;
      hsync_p1       <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      vsync_p1       <= sync_level(1'b0, SYNC_ACTIVE_LOW);
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      if (vld_p0) begin
        x_p1           <= x_p0;
        y_p1           <= y_p0;
        video_on_p1    <= in_window(x_p0, 0, H_ACTIVE) && in_window(y_p0, 0, V_ACTIVE);
        hsync_p1       <= sync_level(in_window(x_p0, HS_START, HS_END), SYNC_ACTIVE_LOW);
        vsync_p1       <= sync_level(in_window(y_p0, VS_START, VS_END), SYNC_ACTIVE_LOW);
        line_start_p1  <= x_wrap_p0;
        frame_start_p1 <= x_wrap_p0 && y_wrap_p0;
      end
    end
  end

  assign vga.pix_tick    = vld_p0;
  assign vga.x           = x_p1;
  assign vga.y           = y_p1;
  assign vga.video_on    = video_on_p1;
  assign vga.hsync       = hsync_p1;
  assign vga.vsync       = vsync_p1;
  assign vga.line_start  = line_start_p1;
  assign vga.frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing plus two reduced
// rasters (16x12) for frame-level vsync, polarity and period checks.
module tb_vga_sync_gen;
  import vga_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  vga_sync_gen_if dflt_if ();
  vga_sync_gen_if hi_if ();
  vga_sync_gen_if lo2_if ();

  vga_sync_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (dflt_if)
  );

  // 16x12 raster, active-high syncs, one clk per pixel
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_ACTIVE_LOW(1'b0), .CLK_DIV(1)
  ) u_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (hi_if)
  );

  // Same raster, active-low syncs, two clks per pixel
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_ACTIVE_LOW(1'b1), .CLK_DIV(2)
  ) u_lo2 (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (lo2_if)
  );

  typedef struct {
    int   wx;
    int   wy;
    int   skip;
    int   ex;
    int   ey;
    logic von;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } vec_t;

  localparam int NV = 15;
  vec_t tv[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_xy(input int tx, input int ty, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(dflt_if.x) == tx && int'(dflt_if.y) == ty) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".x"},        dflt_if.x, 799);
    check({tag, ".y"},        dflt_if.y, 524);
    check({tag, ".video_on"}, dflt_if.video_on, 0);
    check({tag, ".hsync"},    dflt_if.hsync, 1);
    check({tag, ".vsync"},    dflt_if.vsync, 1);
    check({tag, ".pix_tick"}, dflt_if.pix_tick, 0);
    check({tag, ".line_st"},  dflt_if.line_start, 0);
    check({tag, ".frame_st"}, dflt_if.frame_start, 0);
    check({tag, ".hi_x"},     hi_if.x, 15);
    check({tag, ".hi_y"},     hi_if.y, 11);
    check({tag, ".hi_hsync"}, hi_if.hsync, 0);
    check({tag, ".hi_vsync"}, hi_if.vsync, 0);
  endtask

  // Releases reset and follows the default DUT through its first pixel.
  task automatic first_frame(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, ".c1_tick"}, dflt_if.pix_tick, 0);
    check({tag, ".c1_x"},    dflt_if.x, 799);
    @(negedge clk);
    check({tag, ".c2_tick"}, dflt_if.pix_tick, 1);
    check({tag, ".c2_x"},    dflt_if.x, 799);
    check({tag, ".c2_y"},    dflt_if.y, 524);
    @(negedge clk);
    check({tag, ".c3_x"},     dflt_if.x, 0);
    check({tag, ".c3_y"},     dflt_if.y, 0);
    check({tag, ".c3_von"},   dflt_if.video_on, 1);
    check({tag, ".c3_ls"},    dflt_if.line_start, 1);
    check({tag, ".c3_fs"},    dflt_if.frame_start, 1);
    check({tag, ".c3_tick"},  dflt_if.pix_tick, 0);
    check({tag, ".c3_hsync"}, dflt_if.hsync, 1);
    check({tag, ".c3_vsync"}, dflt_if.vsync, 1);
    @(negedge clk);
    check({tag, ".c4_tick"}, dflt_if.pix_tick, 1);
    check({tag, ".c4_x"},    dflt_if.x, 0);
    check({tag, ".c4_fs"},   dflt_if.frame_start, 0);
    check({tag, ".c4_ls"},   dflt_if.line_start, 0);
    @(negedge clk);
    check({tag, ".c5_x"},    dflt_if.x, 1);
    check({tag, ".c5_tick"}, dflt_if.pix_tick, 0);
  endtask

  function automatic logic strobe(input int sel);
    case (sel)
      0:       return hi_if.line_start;
      1:       return hi_if.frame_start;
      2:       return lo2_if.line_start;
      default: return lo2_if.frame_start;
    endcase
  endfunction

  // Clks between two consecutive pulses of the selected strobe, -1 on timeout.
  task automatic measure(input int sel, input int budget, output int period);
    bit seen;
    seen   = 1'b0;
    period = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (strobe(sel)) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      for (int n = 1; n <= budget; n++) begin
        @(negedge clk);
        if (strobe(sel)) begin
          period = n;
          break;
        end
      end
    end
  endtask

  initial begin
    bit   ok;
    int   per;
    int   ex;
    int   ey;
    logic prev_vs;

    //        wx   wy  skip ex   ey  von   hs    vs    ls    fs
    tv[0]  = '{639,  0, 0, 639,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{640,  0, 0, 640,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[2]  = '{655,  0, 0, 655,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{656,  0, 0, 656,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{751,  0, 0, 751,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{752,  0, 0, 752,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{799,  0, 0, 799,  0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[7]  = '{0,    1, 0, 0,    1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{799, 10, 0, 799, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{0,   11, 0, 0,   11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[10] = '{-1,  -1, 1, 0,   11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{-1,  -1, 1, 1,   11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[12] = '{639, 11, 0, 639, 11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[13] = '{640, 11, 0, 640, 11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[14] = '{0,   12, 0, 0,   12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    first_frame("ff1");

    for (int i = 0; i < NV; i++) begin
      ok = 1'b1;
      if (tv[i].wx >= 0) wait_xy(tv[i].wx, tv[i].wy, 20000, ok);
      check($sformatf("v%0d.reached", i), ok, 1);
      if (ok) begin
        repeat (tv[i].skip) @(negedge clk);
        check($sformatf("v%0d.x", i),     dflt_if.x, tv[i].ex);
        check($sformatf("v%0d.y", i),     dflt_if.y, tv[i].ey);
        check($sformatf("v%0d.von", i),   dflt_if.video_on, tv[i].von);
        check($sformatf("v%0d.hsync", i), dflt_if.hsync, tv[i].hs);
        check($sformatf("v%0d.vsync", i), dflt_if.vsync, tv[i].vs);
        check($sformatf("v%0d.ls", i),    dflt_if.line_start, tv[i].ls);
        check($sformatf("v%0d.fs", i),    dflt_if.frame_start, tv[i].fs);
      end
    end

    // Asynchronous reset between edges at (300,12)
    wait_xy(300, 12, 5000, ok);
    check("mid.reached", ok, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_async");
    repeat (2) @(negedge clk);
    check_reset("mid_hold");
    first_frame("ff2");

    // Full 16x12 frame on the active-high, CLK_DIV=1 raster
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (hi_if.frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("hi.frame_seen", ok, 1);
    if (ok) begin
      ex      = 0;
      ey      = 0;
      prev_vs = hi_if.vsync;
      for (int k = 0; k <= 16 * 12; k++) begin
        check($sformatf("hi.x@%0d", k),   hi_if.x, ex);
        check($sformatf("hi.y@%0d", k),   hi_if.y, ey);
        check($sformatf("hi.von@%0d", k), hi_if.video_on, (ex < 8 && ey < 6));
        check($sformatf("hi.hs@%0d", k),  hi_if.hsync, (ex >= 10 && ex < 13));
        check($sformatf("hi.vs@%0d", k),  hi_if.vsync, (ey >= 8 && ey < 10));
        check($sformatf("hi.ls@%0d", k),  hi_if.line_start, (ex == 0));
        check($sformatf("hi.fs@%0d", k),  hi_if.frame_start, (ex == 0 && ey == 0));
        if (hi_if.vsync !== prev_vs) check($sformatf("hi.vs_edge_x@%0d", k), hi_if.x, 0);
        prev_vs = hi_if.vsync;
        ex = ex + 1;
        if (ex == 16) begin
          ex = 0;
          ey = (ey == 11) ? 0 : ey + 1;
        end
        @(negedge clk);
      end
    end

    measure(0, 2000, per);
    check("hi.line_period", per, 16);
    measure(1, 2000, per);
    check("hi.frame_period", per, 192);
    measure(2, 2000, per);
    check("lo2.line_period", per, 32);
    measure(3, 2000, per);
    check("lo2.frame_period", per, 384);

    // Active-low small raster: hsync low only inside x=10..12
    wait (lo2_if.x == 10'd10 || !rst_n);
    @(negedge clk);
    check("lo2.hs_x10", lo2_if.hsync, 0);
    wait (lo2_if.x == 10'd13 || !rst_n);
    @(negedge clk);
    check("lo2.hs_x13", lo2_if.hsync, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
